vga_frame_scanout: RTL and testbench

//  Downstream display stage of the processor. It sits after the memory-write stage, which fills a
//  256x256 8-bit grayscale frame buffer. The block generates 640x480@60 VGA timing from the

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_sync_counter.sv | 80 ++++++++
 rtl/vga_frame_scanout.sv | 99 +++++++++
 tb/tb_vga_frame_scanout.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, image placement and shared types for the scanout path.
// The display modules take these as parameter defaults so that other geometries can be built.
package vga_timing_pkg;

  localparam int CLK_DIV = 4;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int IMG_X0 = 192;
  localparam int IMG_Y0 = 112;
  localparam int IMG_W  = 256;

  // Per-position attributes that travel down the pipeline next to the pixel.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic in_img;
  } raw_sync_t;

  localparam raw_sync_t RAW_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, in_img: 1'b0};

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-tick divider, horizontal/vertical position counters, raw active-low sync and
// image-window decode for the current position.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_VIS   = vga_timing_pkg::H_VIS,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int V_VIS   = vga_timing_pkg::V_VIS,
  parameter int V_FP    = vga_timing_pkg::V_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP,
  parameter int IMG_X0  = vga_timing_pkg::IMG_X0,
  parameter int IMG_Y0  = vga_timing_pkg::IMG_Y0,
  parameter int IMG_W   = vga_timing_pkg::IMG_W,
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int HW = cnt_w(HT),
  localparam int VW = cnt_w(VT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output raw_sync_t     raw
);

  localparam int DW = cnt_w(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
  localparam logic [HW-1:0] HS0      = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS1      = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS0      = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS1      = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [HW-1:0] X0       = HW'(IMG_X0);
  localparam logic [HW-1:0] X1       = HW'(IMG_X0 + IMG_W);
  localparam logic [VW-1:0] Y0       = VW'(IMG_Y0);
  localparam logic [VW-1:0] Y1       = VW'(IMG_Y0 + IMG_W);

  logic [DW-1:0] div;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    raw        = RAW_IDLE;
    raw.hs_n   = !((h_cnt >= HS0) && (h_cnt < HS1));
    raw.vs_n   = !((v_cnt >= VS0) && (v_cnt < VS1));
    raw.in_img = (h_cnt >= X0) && (h_cnt < X1) && (v_cnt >= Y0) && (v_cnt < Y1);
  end

endmodule

// File: rtl/vga_frame_scanout.sv
// VGA scanout: stage1 issues the frame-buffer address one tick ahead, stage2 gates the returned
// pixel into grayscale RGB so colour and sync leave the block aligned, two ticks after the counters.
module vga_frame_scanout
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_VIS   = vga_timing_pkg::H_VIS,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int V_VIS   = vga_timing_pkg::V_VIS,
  parameter int V_FP    = vga_timing_pkg::V_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP,
  parameter int IMG_X0  = vga_timing_pkg::IMG_X0,
  parameter int IMG_Y0  = vga_timing_pkg::IMG_Y0,
  parameter int IMG_W   = vga_timing_pkg::IMG_W,
  localparam int HW = cnt_w(H_VIS + H_FP + H_SYNC + H_BP),
  localparam int VW = cnt_w(V_VIS + V_FP + V_SYNC + V_BP)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] vga_addr,
  input  logic [7:0]  pixel_in,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  logic          tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  raw_sync_t     raw, raw_d1;
  logic          unused_pixel_lsbs;

  assign unused_pixel_lsbs = ^pixel_in[3:0];

  vga_sync_counter #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),  .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS   (V_VIS),  .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .IMG_X0  (IMG_X0), .IMG_Y0 (IMG_Y0), .IMG_W (IMG_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .raw   (raw)
  );

  // Stage1: the address is only refreshed inside the window, so the last pixel's 0xFFFF lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_addr <= '0;
      raw_d1   <= RAW_IDLE;
    end else if (tick) begin
      raw_d1 <= raw;
      if (raw.in_img) begin
        vga_addr <= {8'(v_cnt) - 8'(IMG_Y0), 8'(h_cnt) - 8'(IMG_X0)};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick) begin
      if (raw_d1.in_img && en) begin
        red   <= pixel_in[7:4];
        green <= pixel_in[7:4];
        blue  <= pixel_in[7:4];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
      hsync <= raw_d1.hs_n;
      vsync <= raw_d1.vs_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Directed bench on a shrunken raster (28x19 positions, 8x8 image at (4,3), 2 clks per tick)
// so that whole frames, the image wrap corner and a mid-frame reset fit in a short run.
module tb_vga_frame_scanout;

  localparam int CD = 2;
  localparam int HV = 20, HF = 2, HS = 3, HB = 3, HT = 28;
  localparam int VV = 14, VF = 1, VS = 2, VB = 2, VT = 19;
  localparam int X0 = 4, Y0 = 3, W = 8;
  localparam int FR = HT * VT;                       // 532 ticks per frame
  localparam int LAST = (Y0 + W - 1) * HT + X0 + W - 1;
  localparam int COL5 = Y0 * HT + X0 + 5;
  localparam int EN0  = FR + 2 + (Y0 + 4) * HT + X0 + 1;
  localparam int EN1  = EN0 + 3;
  localparam int RST_POS = (Y0 + 3) * HT + X0 + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [7:0]  pixel_in = 8'h00;
  logic [15:0] vga_addr;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, frame_start;

  bit          mode = 1'b0;
  int          passed = 0, total = 0;
  int          T = 0;
  logic [15:0] exp_addr = 16'h0000;
  int          hl = 0, vl = 0, fsc = 0, last_hf = 0, last_vf = 0;
  logic        prev_hs = 1'b1, prev_vs = 1'b1;

  always #5 clk = ~clk;

  // Synchronous frame buffer: column nibble lands in the pixel's upper nibble.
  always @(posedge clk) pixel_in <= mode ? 8'hFF : {vga_addr[3:0], vga_addr[11:8]};

  vga_frame_scanout #(
    .CLK_DIV (CD),
    .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .IMG_X0 (X0), .IMG_Y0 (Y0), .IMG_W (W)
  ) dut (
    .clk (clk), .rst (rst), .en (en),
    .vga_addr (vga_addr), .pixel_in (pixel_in),
    .red (red), .green (green), .blue (blue),
    .hsync (hsync), .vsync (vsync), .frame_start (frame_start)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got T=%0d required completion", T);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h required %h (tick %0d)", tag, got, exp, T);
  endtask

  function automatic bit img_at(input int pp);
    int h, v;
    h = pp % HT;
    v = pp / HT;
    return (h >= X0) && (h < X0 + W) && (v >= Y0) && (v < Y0 + W);
  endfunction

  task automatic tick_adv();
    repeat (CD) @(posedge clk);
    #1;
    T++;
  endtask

  task automatic run_tick();
    bit         e;
    int         p, pp, q, qq, h, v;
    logic       ehs, evs;
    logic [3:0] ergb;
    e = en;
    tick_adv();
    q  = T - 1;
    qq = q % FR;
    if (img_at(qq)) exp_addr = {8'(qq / HT - Y0), 8'(qq % HT - X0)};
    p = T - 2;
    if (p < 0) begin
      pp = -1; ehs = 1'b1; evs = 1'b1; ergb = 4'h0;
    end else begin
      pp = p % FR;
      h  = pp % HT;
      v  = pp / HT;
      ehs = !((h >= HV + HF) && (h < HV + HF + HS));
      evs = !((v >= VV + VF) && (v < VV + VF + VS));
      ergb = (img_at(pp) && e) ? (mode ? 4'hF : 4'(h - X0)) : 4'h0;
    end
    chk("hsync", 16'(hsync), 16'(ehs));
    chk("vsync", 16'(vsync), 16'(evs));
    chk("rgb", {4'h0, red, green, blue}, {4'h0, ergb, ergb, ergb});
    chk("vga_addr", vga_addr, exp_addr);
    chk("frame_start", 16'(frame_start), 16'(qq == 0));
    if (qq == LAST)     chk("last_pixel_addr", vga_addr, 16'h0707);
    if (qq == LAST + 1) chk("addr_hold_after_img", vga_addr, 16'h0707);
    if (pp == LAST + 1) chk("rgb_past_img", 16'(red), 16'h0);
    if (pp == COL5 && !mode) chk("pix_col5", {4'h0, red, green, blue}, 16'h0555);
    // Per-line/frame sync statistics
    if (!hsync) hl++;
    if (!vsync) vl++;
    if (frame_start) fsc++;
    if (prev_hs && !hsync) begin
      if (last_hf > 0) chk("h_period", 16'(T - last_hf), 16'(HT));
      last_hf = T;
    end
    if (prev_vs && !vsync) begin
      if (last_vf > 0) chk("v_period", 16'(T - last_vf), 16'(FR));
      last_vf = T;
    end
    prev_hs = hsync;
    prev_vs = vsync;
    if (p >= 0 && (pp % HT) == HT - 1) begin
      chk("hs_low_per_line", 16'(hl), 16'(HS));
      hl = 0;
    end
    if (p >= 0 && pp == FR - 1) begin
      chk("vs_low_per_frame", 16'(vl), 16'(VS * HT));
      vl = 0;
    end
    if (T == FR) chk("one_frame_start", 16'(fsc), 16'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", vga_addr, 16'h0000);
    chk("rst_rgb", {4'h0, red, green, blue}, 16'h0000);
    chk("rst_hsync", 16'(hsync), 16'd1);
    chk("rst_vsync", 16'(vsync), 16'd1);
    chk("rst_frame_start", 16'(frame_start), 16'd0);

    @(negedge clk);
    rst = 1'b0;

    // Two full frames: frame 1 with the address-pattern buffer, frame 2 white with an en dip.
    while (T < 2 * FR + 2) begin
      run_tick();
      if (T == FR + 2) mode = 1'b1;
      if (T == EN0) en = 1'b0;
      if (T == EN0 + 1) chk("en_off_rgb", {4'h0, red, green, blue}, 16'h0000);
      if (T == EN1) en = 1'b1;
      if (T == EN1 + 1) chk("en_on_rgb", {4'h0, red, green, blue}, 16'h0FFF);
    end

    // Mid-frame asynchronous reset while white pixels are on the pins.
    for (int i = 0; i < FR && ((T - 2) % FR) != RST_POS; i++) run_tick();
    chk("pre_rst_rgb", {4'h0, red, green, blue}, 16'h0FFF);
    rst = 1'b1;
    #1;
    chk("mid_rst_rgb", {4'h0, red, green, blue}, 16'h0000);
    chk("mid_rst_hsync", 16'(hsync), 16'd1);
    chk("mid_rst_vsync", 16'(vsync), 16'd1);
    chk("mid_rst_addr", vga_addr, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("held_rst_rgb", {4'h0, red, green, blue}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    T = 0; exp_addr = 16'h0000; hl = 0; vl = 0; fsc = 0;
    last_hf = 0; last_vf = 0; prev_hs = 1'b1; prev_vs = 1'b1;
    run_tick();
    chk("fs_first_tick_after_rst", 16'(frame_start), 16'd1);
    repeat (2 * HT) run_tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
